// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                  |
// | Purpose  : UART transmitter with input FIFO, parity and stop-bit options |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int B_PER_T    = 8,
   parameter int BR         = 9600,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [B_PER_T-1:0]                i_data,
   input  logic                              i_dv,
   output logic                              o_ready,
   output logic                              o_tx,
   output logic                              o_busy,
   output logic                              o_tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count
);

   localparam int c_baud_ticks = CLK_FREQ / BR;
   localparam int c_baud_w     = (c_baud_ticks > 1) ? $clog2(c_baud_ticks) : 1;
   localparam int c_idx_w      = $clog2(B_PER_T + 1);
   localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w      = $clog2(FIFO_DEPTH + 1);

   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_baud_ticks - 1);
   localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
   localparam logic [c_idx_w-1:0]  c_data_last = c_idx_w'(B_PER_T - 1);
   localparam logic [c_idx_w-1:0]  c_stop_last = c_idx_w'(STOP_BITS - 1);
   localparam logic [c_idx_w-1:0]  c_idx_one   = c_idx_w'(1);
   localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
   localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(FIFO_DEPTH);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_start  = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_parity = 3'd3;
   localparam logic [2:0] c_st_stop   = 3'd4;

   logic [B_PER_T-1:0]  r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic [2:0]          r_state;
   logic [2:0]          w_state_next;
   logic [c_baud_w-1:0] r_baud;
   logic [c_idx_w-1:0]  r_idx;
   logic [B_PER_T-1:0]  r_shreg;
   logic                r_par;
   logic                r_tx;
   logic                r_busy;
   logic                r_done;
   logic                w_tx_next;
   logic                w_busy_next;
   logic                w_done_next;
   logic                w_push;
   logic                w_pop;
   logic                w_baud_end;
   logic [B_PER_T-1:0]  w_head;

   // A full FIFO refuses writes even when the same edge pops a word.
   assign o_ready    = (r_count != c_full);
   assign o_count    = r_count;
   assign w_push     = i_dv && o_ready;
   assign w_pop      = (r_state == c_st_idle) && (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_baud_end = (r_baud == c_baud_last);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle:   if (r_count != '0) w_state_next = c_st_start;
         c_st_start:  if (w_baud_end) w_state_next = c_st_data;
         c_st_data:   if (w_baud_end && (r_idx == c_data_last))
                         w_state_next = (PARITY != 0) ? c_st_parity : c_st_stop;
         c_st_parity: if (w_baud_end) w_state_next = c_st_stop;
         c_st_stop:   if (w_baud_end && (r_idx == c_stop_last)) w_state_next = c_st_idle;
         default:     w_state_next = c_st_idle;
      endcase
   end

   // Baud and bit-index counters restart on every state change.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_baud  <= '0;
         r_idx   <= '0;
         r_shreg <= '0;
         r_par   <= 1'b0;
      end else begin
         if (w_pop) begin
            r_shreg <= w_head;
            r_par   <= (PARITY == 1) ? ~(^w_head) : (^w_head);
         end else if ((r_state == c_st_data) && w_baud_end) begin
            r_shreg <= r_shreg >> 1;
         end
         if (w_state_next != r_state) begin
            r_baud <= '0;
            r_idx  <= '0;
         end else if (r_state != c_st_idle) begin
            if (w_baud_end) begin
               r_baud <= '0;
               r_idx  <= r_idx + c_idx_one;
            end else begin
               r_baud <= r_baud + c_baud_one;
            end
         end
      end
   end

   always_comb begin
      w_tx_next   = 1'b1;
      w_busy_next = 1'b0;
      w_done_next = 1'b0;
      case (r_state)
         c_st_start: begin
            w_tx_next   = 1'b0;
            w_busy_next = 1'b1;
         end
         c_st_data: begin
            w_tx_next   = r_shreg[0];
            w_busy_next = 1'b1;
         end
         c_st_parity: begin
            w_tx_next   = r_par;
            w_busy_next = 1'b1;
         end
         c_st_stop: begin
            w_busy_next = 1'b1;
            w_done_next = w_baud_end && (r_idx == c_stop_last);
         end
         default: ;
      endcase
   end

   // Line outputs are registered together so o_busy and o_tx_done track o_tx.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tx   <= w_tx_next;
         r_busy <= w_busy_next;
         r_done <= w_done_next;
      end
   end

   assign o_tx      = r_tx;
   assign o_busy    = r_busy;
   assign o_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                               |
// | Purpose  : scoreboard bench for uart_tx_fifo in four frame formats       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_fifo;

   localparam int c_baud = 10;

   typedef struct {
      int          inst;
      logic [15:0] bits;   // bit periods, index 0 = start bit
      int          nbits;
   } frame_t;

   logic       clk;
   logic       rst;
   logic       dv     [4];
   logic [7:0] dat    [4];
   logic       tx_v   [4];
   logic       busy_v [4];
   logic       done_v [4];
   logic       ready_v[4];
   logic [2:0] cnt_v  [4];

   int     n_checks;
   int     n_errors;
   frame_t sb_q [$];
   frame_t cur  [4];
   int     mst[4], cyc[4], idle_cnt[4], bad[4], first_bad[4];
   int     done_n[4], done_at[4], busy_bad[4], stray[4], frames[4];
   logic   b2b[4];

   uart_tx_fifo #(.B_PER_T(8), .BR(100_000), .CLK_FREQ(1_000_000), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[0]), .i_dv(dv[0]), .o_ready(ready_v[0]),
      .o_tx(tx_v[0]), .o_busy(busy_v[0]), .o_tx_done(done_v[0]), .o_count(cnt_v[0]));

   uart_tx_fifo #(.B_PER_T(8), .BR(100_000), .CLK_FREQ(1_000_000), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_8e2 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[1]), .i_dv(dv[1]), .o_ready(ready_v[1]),
      .o_tx(tx_v[1]), .o_busy(busy_v[1]), .o_tx_done(done_v[1]), .o_count(cnt_v[1]));

   uart_tx_fifo #(.B_PER_T(8), .BR(100_000), .CLK_FREQ(1_000_000), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_8o2 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[2]), .i_dv(dv[2]), .o_ready(ready_v[2]),
      .o_tx(tx_v[2]), .o_busy(busy_v[2]), .o_tx_done(done_v[2]), .o_count(cnt_v[2]));

   uart_tx_fifo #(.B_PER_T(5), .BR(100_000), .CLK_FREQ(1_000_000), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_5n1 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[3][4:0]), .i_dv(dv[3]), .o_ready(ready_v[3]),
      .o_tx(tx_v[3]), .o_busy(busy_v[3]), .o_tx_done(done_v[3]), .o_count(cnt_v[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] w);
      return {7'h7F, w, 1'b0};
   endfunction

   task automatic push_f(input int i, input logic [15:0] b, input int n);
      sb_q.push_back('{inst: i, bits: b, nbits: n});
   endtask

   function automatic int find_q(input int i);
      for (int k = 0; k < sb_q.size(); k++) if (sb_q[k].inst == i) return k;
      return -1;
   endfunction

   function automatic int count_q(input int i);
      int n = 0;
      for (int k = 0; k < sb_q.size(); k++) if (sb_q[k].inst == i) n++;
      return n;
   endfunction

   task automatic purge(input int i);
      for (int k = sb_q.size() - 1; k >= 0; k--) if (sb_q[k].inst == i) sb_q.delete(k);
   endtask

   // Per-instance frame monitor: pops the expected frame at each start bit.
   task automatic mon_step(input int i);
      int   k;
      logic exp_bit;
      if (rst !== 1'b0) begin
         mst[i] = 0; idle_cnt[i] = 0; b2b[i] = 1'b0;
         purge(i);
      end else begin
         if (mst[i] == 0) begin
            if (tx_v[i] === 1'b0) begin
               frames[i]++;
               if (b2b[i]) chk($sformatf("b2b_gap inst%0d", i), idle_cnt[i], 1);
               b2b[i] = 1'b0;
               k = find_q(i);
               chk($sformatf("frame_expected inst%0d", i), (k >= 0), 1);
               if (k >= 0) begin
                  cur[i] = sb_q[k];
                  sb_q.delete(k);
               end else begin
                  cur[i] = '{inst: i, bits: 16'h0, nbits: 10};
               end
               mst[i] = 1; cyc[i] = 1; bad[i] = 0; first_bad[i] = 0;
               done_n[i] = 0; done_at[i] = 0; busy_bad[i] = 0;
            end else begin
               idle_cnt[i]++;
               if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) stray[i]++;
               if (b2b[i] && idle_cnt[i] > 1) begin
                  chk($sformatf("b2b_gap inst%0d", i), idle_cnt[i], 1);
                  b2b[i] = 1'b0;
               end
            end
         end
         if (mst[i] == 1) begin
            exp_bit = cur[i].bits[(cyc[i] - 1) / c_baud];
            if (tx_v[i] !== exp_bit) begin
               bad[i]++;
               if (first_bad[i] == 0) first_bad[i] = cyc[i];
            end
            if (busy_v[i] !== 1'b1) busy_bad[i]++;
            if (done_v[i] !== 1'b0) begin
               done_n[i]++;
               done_at[i] = cyc[i];
            end
            if (cyc[i] == cur[i].nbits * c_baud) begin
               chk($sformatf("frame_tx inst%0d bits=%04h first_bad_cycle=%0d", i,
                             cur[i].bits, first_bad[i]), bad[i], 0);
               chk($sformatf("tx_done_count inst%0d", i), done_n[i], 1);
               chk($sformatf("tx_done_cycle inst%0d", i), done_at[i], cur[i].nbits * c_baud);
               chk($sformatf("busy_in_frame inst%0d", i), busy_bad[i], 0);
               mst[i] = 0;
               idle_cnt[i] = 0;
               b2b[i] = (find_q(i) >= 0);
            end else begin
               cyc[i]++;
            end
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) mon_step(i);
      end
   endtask

   task automatic wait_done(input int i, input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done_v[i] !== 1'b1 && n < lim);
      chk($sformatf("wait_done inst%0d", i), done_v[i], 1);
   endtask

   initial begin
      int n;
      int snap;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dv[i] = 1'b0; dat[i] = 8'h00;
         mst[i] = 0; cyc[i] = 0; idle_cnt[i] = 0; bad[i] = 0; first_bad[i] = 0;
         done_n[i] = 0; done_at[i] = 0; busy_bad[i] = 0; stray[i] = 0; frames[i] = 0;
         b2b[i] = 1'b0;
      end
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_tx", tx_v[0], 1);
      chk("rst_ready", ready_v[0], 1);
      chk("rst_busy", busy_v[0], 0);
      chk("rst_done", done_v[0], 0);
      chk("rst_count", cnt_v[0], 0);
      rst = 1'b0;

      // 8N1 0xA5 and first-frame latency
      push_f(0, 16'hFF4A, 10);
      @(negedge clk); dv[0] = 1'b1; dat[0] = 8'hA5;
      @(negedge clk); dv[0] = 1'b0; dat[0] = 8'h3C;
      chk("lat_n_tx", tx_v[0], 1);
      chk("lat_n_count", cnt_v[0], 1);
      @(negedge clk);
      chk("lat_n1_tx", tx_v[0], 1);
      chk("lat_n1_count", cnt_v[0], 0);
      chk("lat_n1_busy", busy_v[0], 0);
      @(negedge clk);
      chk("lat_n2_tx", tx_v[0], 0);
      chk("lat_n2_busy", busy_v[0], 1);
      wait_done(0, 200);
      repeat (5) @(negedge clk);
      chk("dv_low_ignored_count", cnt_v[0], 0);

      // 8E2, 8O2 and 5N1 frames in parallel
      push_f(1, 16'hFD4A, 12);
      push_f(2, 16'hFF4A, 12);
      push_f(3, 16'hFFFE, 7);
      @(negedge clk);
      dv[1] = 1'b1; dat[1] = 8'hA5;
      dv[2] = 1'b1; dat[2] = 8'hA5;
      dv[3] = 1'b1; dat[3] = 8'hFF;
      @(negedge clk);
      dv[1] = 1'b0; dv[2] = 1'b0; dv[3] = 1'b0;
      chk("f5_count", cnt_v[3], 1);
      repeat (140) @(negedge clk);

      // FIFO overflow: 0x01..0x05 accepted, 0x06 dropped
      for (int k = 1; k <= 5; k++) push_f(0, f8n1(8'(k)), 10);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); dv[0] = 1'b1; dat[0] = 8'(k);
      end
      @(negedge clk); dv[0] = 1'b0;
      chk("full_count", cnt_v[0], 4);
      chk("full_ready", ready_v[0], 0);
      for (int f = 0; f < 5; f++) wait_done(0, 200);
      repeat (3) @(negedge clk);
      chk("drain_count", cnt_v[0], 0);

      // Writes coinciding with IDLE pops
      for (int k = 1; k <= 5; k++) push_f(0, f8n1(8'(16 + k)), 10);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); dv[0] = 1'b1; dat[0] = 8'(16 + k);
      end
      @(negedge clk); dv[0] = 1'b0;
      chk("fill4_count", cnt_v[0], 4);
      chk("fill4_ready", ready_v[0], 0);
      wait_done(0, 200);
      dv[0] = 1'b1; dat[0] = 8'h99;
      @(negedge clk); dv[0] = 1'b0;
      chk("drop_on_pop_count", cnt_v[0], 3);
      chk("drop_on_pop_ready", ready_v[0], 1);
      wait_done(0, 200);
      dv[0] = 1'b1; dat[0] = 8'h16;
      push_f(0, f8n1(8'h16), 10);
      @(negedge clk); dv[0] = 1'b0;
      chk("write_with_pop_count", cnt_v[0], 3);
      for (int f = 0; f < 4; f++) wait_done(0, 200);
      repeat (3) @(negedge clk);
      chk("drain2_count", cnt_v[0], 0);

      // Reset at cycle 45 of a frame with two words queued
      for (int k = 0; k < 3; k++) push_f(0, f8n1(8'(33 + k)), 10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); dv[0] = 1'b1; dat[0] = 8'(33 + k);
      end
      @(negedge clk); dv[0] = 1'b0;
      chk("pre_rst_count", cnt_v[0], 2);
      n = 0;
      while (tx_v[0] !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_frame_started", tx_v[0], 0);
      repeat (44) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", tx_v[0], 1);
      chk("midrst_count", cnt_v[0], 0);
      chk("midrst_busy", busy_v[0], 0);
      chk("midrst_ready", ready_v[0], 1);
      snap = frames[0];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      chk("no_frame_after_rst", frames[0] - snap, 0);
      chk("post_rst_count", cnt_v[0], 0);

      chk("frames_inst0", frames[0], 13);
      for (int i = 1; i < 4; i++) chk($sformatf("frames_inst%0d", i), frames[i], 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sb_drain inst%0d", i), count_q(i), 0);
         chk($sformatf("idle_outputs inst%0d", i), stray[i], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
